// File: rtl/spi_ram_master_if.sv
// Command/response bundle between the OBI shim and the SPI RAM serial engine.
// The shim side uses the master modport; the engine uses the slave modport.
interface spi_ram_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [23:0] cmd_addr_i;
  logic [1:0]  cmd_size_i;
  logic [31:0] cmd_wdata_i;
  logic [4:0]  clk_div_hi_i;
  logic [4:0]  clk_div_lo_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_size_i, cmd_wdata_i,
           clk_div_hi_i, clk_div_lo_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_size_i, cmd_wdata_i,
           clk_div_hi_i, clk_div_lo_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/spi_ram_master.sv
// Serial-side engine for SPI mode-0 RAMs (23LC / APS style).
// One command at a time: instruction, address and data are shifted out MSB
// first, MISO is captured during the read data phase, and a single-cycle
// response carries the little-endian read data.
// Optional build macro SPI_RAM_MASTER_FAST_READ_EN: reads use the 0x0B fast
// read instruction followed by 8 dummy SCK cycles.
module spi_ram_master #(
  parameter int unsigned AddrBytes = 3,
  parameter logic [7:0]  ReadCmd   = 8'h03,
  parameter logic [7:0]  WriteCmd  = 8'h02
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  spi_ram_master_if.slave   bus,
  output logic              spi_sck_o,
  output logic              spi_cs_no,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i
);

  localparam int unsigned AddrW = 8 * AddrBytes;
  localparam int unsigned TxW   = 8 + AddrW + 32;

`ifdef SPI_RAM_MASTER_FAST_READ_EN
  localparam logic [7:0] RdInstr = 8'h0B;
  localparam logic [6:0] RdDummy = 7'd8;
`else
  localparam logic [7:0] RdInstr = ReadCmd;
  localparam logic [6:0] RdDummy = 7'd0;
`endif

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP, DONE
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;        // cycles left in the current phase
  logic [4:0]     hi_q, hi_d;
  logic [4:0]     lo_q, lo_d;
  logic           sck_hi_q, sck_hi_d;
  logic [6:0]     bits_q, bits_d;      // bits left, including the one on the wire
  logic [6:0]     dbits_q, dbits_d;    // length of the data phase
  logic           we_q, we_d;
  logic [1:0]     size_q, size_d;
  logic [TxW-1:0] tx_q, tx_d;
  logic [31:0]    rx_q, rx_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  logic [31:0]    wdata_wire;          // write bytes in wire order, byte 0 first
  logic [31:0]    rx_word;             // captured word put back in little-endian order
  logic [31:0]    rx_fmt;
  logic [6:0]     dbits_load;
  logic [6:0]     nb_load;

  // Byte reordering between the little-endian bus and the byte-0-first wire.
  for (genvar gi = 0; gi < 4; gi++) begin : g_swap
    assign wdata_wire[8*(3-gi) +: 8] = bus.cmd_wdata_i[8*gi +: 8];
    assign rx_word[8*gi +: 8]        = rx_q[8*(3-gi) +: 8];
  end

  // Sub-word reads end with the last received byte in rx_q[7:0].
  always_comb begin
    rx_fmt = 32'h0;
    case (size_q)
      2'd0:    rx_fmt = {24'h0, rx_q[7:0]};
      2'd1:    rx_fmt = {16'h0, rx_q[7:0], rx_q[15:8]};
      default: rx_fmt = rx_word;
    endcase
  end

  assign dbits_load = 7'd8 << bus.cmd_size_i;
  assign nb_load    = 7'(8 + AddrW) + dbits_load + (bus.cmd_we_i ? 7'd0 : RdDummy);

  // State register and latched command context.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sck_hi_q <= 1'b0;
      bits_q   <= '0;
      dbits_q  <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sck_hi_q <= sck_hi_d;
      bits_q   <= bits_d;
      dbits_q  <= dbits_d;
      we_q     <= we_d;
      size_q   <= size_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: phase counters reload at every phase boundary.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sck_hi_d = sck_hi_q;
    bits_d   = bits_q;
    dbits_d  = dbits_q;
    we_d     = we_q;
    size_d   = size_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          we_d     = bus.cmd_we_i;
          size_d   = bus.cmd_size_i;
          hi_d     = bus.clk_div_hi_i;
          lo_d     = bus.clk_div_lo_i;
          bits_d   = nb_load;
          dbits_d  = dbits_load;
          rx_d     = 32'h0;
          sck_hi_d = 1'b0;
          // Read data and fast-read dummy bits fall in the zero tail.
          tx_d     = {(bus.cmd_we_i ? WriteCmd : RdInstr),
                      bus.cmd_addr_i[AddrW-1:0],
                      (bus.cmd_we_i ? wdata_wire : 32'h0)};
          if (bus.cmd_size_i == 2'd3) begin
            // Reserved size: skip the bus entirely, one turnaround cycle.
            state_d = CS_GAP;
            cnt_d   = 5'd0;
          end else begin
            state_d = CS_SETUP;
            cnt_d   = bus.clk_div_lo_i;
          end
        end
      end
      CS_SETUP: begin
        if (cnt_q == 5'd0) begin
          state_d  = SHIFT;
          sck_hi_d = 1'b1;
          cnt_d    = hi_q;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else if (sck_hi_q) begin
          // End of high phase: sample MISO in the read data phase only.
          if (!we_q && (bits_q <= dbits_q)) begin
            rx_d = {rx_q[30:0], spi_miso_i};
          end
          sck_hi_d = 1'b0;
          cnt_d    = lo_q;
          if (bits_q == 7'd1) begin
            state_d = CS_HOLD;
          end else begin
            tx_d   = tx_q << 1;
            bits_d = bits_q - 7'd1;
          end
        end else begin
          sck_hi_d = 1'b1;
          cnt_d    = hi_q;
        end
      end
      CS_HOLD: begin
        if (cnt_q == 5'd0) begin
          state_d = CS_GAP;
          cnt_d   = lo_q;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      CS_GAP: begin
        // CS deselected; response fields are loaded on the way into DONE.
        if (cnt_q == 5'd0) begin
          state_d = DONE;
          err_d   = (size_q == 2'd3);
          rdata_d = (we_q || size_q == 2'd3) ? 32'h0 : rx_fmt;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin and handshake decode straight from registered state.
  always_comb begin
    bus.cmd_ready_o = (state_q == IDLE);
    bus.rsp_valid_o = (state_q == DONE);
    bus.rsp_rdata_o = rdata_q;
    bus.rsp_err_o   = err_q;
    spi_cs_no       = !((state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD));
    spi_sck_o       = (state_q == SHIFT) && sck_hi_q;
    spi_mosi_o      = spi_cs_no ? 1'b0 : tx_q[TxW-1];
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed self-checking bench for spi_ram_master (AddrBytes = 3).
// Acts as the command master and as a simple SPI RAM model on MISO.
module tb_spi_ram_master;

`ifdef SPI_RAM_MASTER_FAST_READ_EN
  localparam int         FR      = 1;
  localparam logic [7:0] RD_INSTR = 8'h0B;
`else
  localparam int         FR      = 0;
  localparam logic [7:0] RD_INSTR = 8'h03;
`endif

  logic clk;
  logic rst_n;
  logic sck, cs_n, mosi, miso;
  int   cyc;
  int   n_checks;
  int   n_pass;

  spi_ram_master_if bus();

  spi_ram_master dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .spi_sck_o  (sck),
    .spi_cs_no  (cs_n),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one command, watch the wire until the response, then compare.
  task automatic run_cmd(input string name, input logic we, input logic [23:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input logic [4:0] hi, input logic [4:0] lo,
                         input logic [31:0] miso_word, input int nb,
                         input logic [71:0] exp_mosi, input logic [31:0] exp_rdata,
                         input int exp_lat);
    int          n;
    int          t_acc;
    int          rsp_cyc;
    int          rises;
    int          cs_low;
    int          sck_high;
    int          b;
    int          hdr;
    int          exp_cs;
    logic        prev;
    logic        done;
    logic [71:0] got;
    logic [31:0] rdata;
    logic        err;
    hdr = we ? 32 : 32 + 8 * FR;
    @(negedge clk);
    miso             = 1'b1;
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_we_i     = we;
    bus.cmd_addr_i   = addr;
    bus.cmd_size_i   = size;
    bus.cmd_wdata_i  = wdata;
    bus.clk_div_hi_i = hi;
    bus.clk_div_lo_i = lo;
    n = 0;
    while (!bus.cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_timeout"}, 72'(bus.cmd_ready_o), 72'd1);
    t_acc = cyc;
    rises = 0; cs_low = 0; sck_high = 0; prev = 1'b0; done = 1'b0;
    got = '0; rsp_cyc = 0; rdata = '0; err = 1'b0;
    for (int k = 0; k < 20000 && !done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Scramble every input once the command is in flight.
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_we_i     = ~we;
        bus.cmd_addr_i   = ~addr;
        bus.cmd_size_i   = ~size;
        bus.cmd_wdata_i  = ~wdata;
        bus.clk_div_hi_i = ~hi;
        bus.clk_div_lo_i = ~lo;
      end
      if (!cs_n) cs_low++;
      if (sck) sck_high++;
      if (sck && !prev) begin
        if (rises < 72) got[71 - rises] = mosi;
        rises++;
      end
      prev = sck;
      if (sck) begin
        b = rises - 1;
        if (b >= hdr && (b - hdr) < 32) miso = miso_word[8 * ((b - hdr) / 8) + 7 - ((b - hdr) % 8)];
        else miso = 1'b1;
      end
      if (bus.rsp_valid_o) begin
        done    = 1'b1;
        rsp_cyc = cyc;
        rdata   = bus.rsp_rdata_o;
        err     = bus.rsp_err_o;
      end
    end
    check({name, "_rsp_timeout"}, 72'(done), 72'd1);
    exp_cs = nb * (hi + 1) + (nb - 1) * (lo + 1) + 2 * (lo + 1);
    check({name, "_latency"}, 72'(rsp_cyc - t_acc), 72'(exp_lat));
    check({name, "_rdata"}, 72'(rdata), 72'(exp_rdata));
    check({name, "_err"}, 72'(err), 72'd0);
    check({name, "_mosi"}, got, exp_mosi);
    check({name, "_nbits"}, 72'(rises), 72'(nb));
    check({name, "_cs_low"}, 72'(cs_low), 72'(exp_cs));
    check({name, "_sck_high"}, 72'(sck_high), 72'(nb * (hi + 1)));
    @(negedge clk);
    check({name, "_pulse_1cyc"}, 72'(bus.rsp_valid_o), 72'd0);
    check({name, "_rdata_held"}, 72'(bus.rsp_rdata_o), 72'(exp_rdata));
    $display("txn %s: lat=%0d rdata=%08h err=%0b bits=%0d cs_low=%0d", name,
             rsp_cyc - t_acc, rdata, err, rises, cs_low);
  endtask

  initial begin
    int   n;
    int   t0;
    int   r1;
    int   r2;
    int   rises;
    logic prev;
    logic act;
    logic saw;
    logic err1;
    logic [2:0] rdy;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    miso     = 1'b0;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_we_i     = 1'b0;
    bus.cmd_addr_i   = '0;
    bus.cmd_size_i   = '0;
    bus.cmd_wdata_i  = '0;
    bus.clk_div_hi_i = '0;
    bus.clk_div_lo_i = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ready", 72'(bus.cmd_ready_o), 72'd1);
    check("rst_rsp_valid", 72'(bus.rsp_valid_o), 72'd0);
    check("rst_rdata", 72'(bus.rsp_rdata_o), 72'd0);
    check("rst_err", 72'(bus.rsp_err_o), 72'd0);
    check("rst_sck", 72'(sck), 72'd0);
    check("rst_cs", 72'(cs_n), 72'd1);
    check("rst_mosi", 72'(mosi), 72'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd("wr_word", 1'b1, 24'h000010, 2'd2, 32'hA1B2C3D4, 5'd0, 5'd0, 32'hFFFFFFFF,
            64, 72'h02000010D4C3B2A100, 32'h0, 131);
    run_cmd("rd_byte", 1'b0, 24'h0000FF, 2'd0, 32'h0, 5'd0, 5'd0, 32'h0000005A,
            40 + 8 * FR, {RD_INSTR, 24'h0000FF, 40'h0}, 32'h0000005A, 83 + FR * 16);
    run_cmd("rd_half", 1'b0, 24'h000040, 2'd1, 32'h0, 5'd2, 5'd1, 32'h00001234,
            48 + 8 * FR, {RD_INSTR, 24'h000040, 40'h0}, 32'h00001234, 245 + FR * 40);
    run_cmd("wr_byte", 1'b1, 24'h00ABCD, 2'd0, 32'h77665544, 5'd0, 5'd2, 32'hFFFFFFFF,
            40, 72'h0200ABCD4400000000, 32'h0, 167);
    run_cmd("rd_word", 1'b0, 24'hABCDEF, 2'd2, 32'h0, 5'd1, 5'd0, 32'hDEADBEEF,
            64 + 8 * FR, {RD_INSTR, 24'hABCDEF, 40'h0}, 32'hDEADBEEF, 195 + FR * 24);

    // Reserved size with valid held: error response, then re-accept.
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_size_i  = 2'd3;
    n = 0;
    while (!bus.cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc; r1 = -1; r2 = -1; act = 1'b0; rdy = '0; err1 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) bus.cmd_valid_i = 1'b0;
      if (k <= 3) rdy[k-1] = bus.cmd_ready_o;
      if (!cs_n || sck) act = 1'b1;
      if (bus.rsp_valid_o) begin
        if (r1 < 0) begin
          r1   = cyc - t0;
          err1 = bus.rsp_err_o;
        end else if (r2 < 0) begin
          r2 = cyc - t0;
        end
      end
    end
    check("rsv_rsp_lat", 72'(r1), 72'd2);
    check("rsv_err", 72'(err1), 72'd1);
    check("rsv_ready_seq", 72'(rdy), 72'b100);
    check("rsv_second_rsp", 72'(r2), 72'd5);
    check("rsv_no_spi", 72'(act), 72'd0);
    check("rsv_rdata", 72'(bus.rsp_rdata_o), 72'd0);
    $display("txn rsv_size: rsp1=T+%0d rsp2=T+%0d err=%0b", r1, r2, err1);

    // Reset in the data phase of a write.
    @(negedge clk);
    miso             = 1'b0;
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_we_i     = 1'b1;
    bus.cmd_addr_i   = 24'h000123;
    bus.cmd_size_i   = 2'd2;
    bus.cmd_wdata_i  = 32'h55AA55AA;
    bus.clk_div_hi_i = 5'd0;
    bus.clk_div_lo_i = 5'd0;
    n = 0;
    while (!bus.cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 40 && n < 1000) begin
      @(negedge clk);
      if (sck && !prev) rises++;
      prev = sck;
      n++;
    end
    check("mid_reach_data", 72'(rises), 72'd40);
    check("mid_cs_active", 72'(cs_n), 72'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs", 72'(cs_n), 72'd1);
    check("mid_rst_sck", 72'(sck), 72'd0);
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid_o) saw = 1'b1;
    end
    check("mid_rst_no_rsp", 72'(saw), 72'd0);
    check("mid_rst_rdata", 72'(bus.rsp_rdata_o), 72'd0);
    rst_n = 1'b1;
    $display("txn mid_reset: reset after %0d bits, rsp_seen=%0b", rises, saw);

    run_cmd("rd_after_rst", 1'b0, 24'h000200, 2'd0, 32'h0, 5'd0, 5'd0, 32'h000000C3,
            40 + 8 * FR, {RD_INSTR, 24'h000200, 40'h0}, 32'h000000C3, 83 + FR * 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
